// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the bypassing multi-port register file.
// Holds the default geometry and the error-cause encoding used by the
// top level to build err and by benches to interpret it.
package rf_pkg;

    localparam int RF_DW    = 16;
    localparam int RF_NREGS = 8;
    localparam int RF_NRD   = 2;
    localparam int RF_NWR   = 2;

    // Highest-priority cause active in a cycle; ERR_NONE means err=0.
    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_COLLIDE  = 3'd1,
        ERR_RANGE_RD = 3'd2,
        ERR_RANGE_WR = 3'd3,
        ERR_X        = 3'd4
    } err_cause_e;

endpackage

// File: rtl/rf_bypass_port.sv
// rf_bypass_port: one combinational read port of rf_bypass_mp.
// Looks up the addressed register, overrides it with same-cycle write data
// (higher-numbered write port wins) and flags out-of-range selects.
// Optional macro RF_R0_ZERO_EN: register 0 always reads as zero.
// Ports:
//   rst_n      - reset (active low); forces rd_data to zero while low
//   rd_sel     - read select
//   mem        - current register contents
//   wr_commit  - per write port: enabled, in range, and allowed to write
//   wr_sel     - packed write selects
//   wr_data    - packed write data
//   rd_data    - read result
//   range_err  - rd_sel addresses a register that does not exist
module rf_bypass_port #(
    parameter int DW    = 16,
    parameter int NREGS = 8,
    parameter int NWR   = 2,
    parameter int SELW  = $clog2(NREGS)
) (
    input  logic                rst_n,
    input  logic [SELW-1:0]     rd_sel,
    input  logic [DW-1:0]       mem [NREGS],
    input  logic [NWR-1:0]      wr_commit,
    input  logic [NWR*SELW-1:0] wr_sel,
    input  logic [NWR*DW-1:0]   wr_data,
    output logic [DW-1:0]       rd_data,
    output logic                range_err
);

    always_comb begin
        rd_data   = '0;
        range_err = !(32'(rd_sel) < NREGS);
        // Out-of-range selects match no register and so fall through as 0.
        for (int r = 0; r < NREGS; r++) begin
            if (rd_sel == SELW'(r)) begin
                rd_data = mem[r];
            end
        end
        // Ascending scan: port 1 overrides port 0, matching the commit order.
        for (int w = 0; w < NWR; w++) begin
            if (wr_commit[w] && (wr_sel[w*SELW +: SELW] == rd_sel)) begin
                rd_data = wr_data[w*DW +: DW];
            end
        end
`ifdef RF_R0_ZERO_EN
        if (rd_sel == '0) begin
            rd_data = '0;
        end
`endif
        if (!rst_n) begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/rf_bypass_mp.sv
// rf_bypass_mp: parametrised multi-port register file with write-to-read
// bypass, deterministic collision resolution (write port 1 wins) and a
// sticky error flag.
// Optional macro RF_R0_ZERO_EN: register 0 is hardwired to zero.
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset, clears all state
//   rd_sel     - packed read selects, port i at [i*SELW +: SELW]
//   rd_data    - packed combinational read data, port i at [i*DW +: DW]
//   wr_en      - per-port write enable
//   wr_sel     - packed write selects
//   wr_data    - packed write data
//   err        - combinational error for the current cycle
//   err_sticky - registered OR of err, held until reset
module rf_bypass_mp
    import rf_pkg::*;
#(
    parameter int DW    = RF_DW,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD,
    parameter int NWR   = RF_NWR,
    parameter int SELW  = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*SELW-1:0] rd_sel,
    output logic [NRD*DW-1:0]   rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*SELW-1:0] wr_sel,
    input  logic [NWR*DW-1:0]   wr_data,
    output logic                err,
    output logic                err_sticky
);

    logic [DW-1:0]   mem_q [NREGS];
    logic [SELW-1:0] wr_sel_a [NWR];
    logic [DW-1:0]   wr_data_a [NWR];
    logic [NWR-1:0]  wr_range_ok;
    logic [NWR-1:0]  wr_commit;
    logic [NRD-1:0]  rd_range_err;
    logic            wr_collide;
    logic            wr_range_err;
    logic            x_err;
    err_cause_e      err_cause;
    logic            err_sticky_reg;

    // Write decode: a port commits only when enabled and addressing a real
    // (and, with the zero register, writable) register.
    for (genvar gi = 0; gi < NWR; gi++) begin : g_wr
        assign wr_sel_a[gi]    = wr_sel[gi*SELW +: SELW];
        assign wr_data_a[gi]   = wr_data[gi*DW +: DW];
        assign wr_range_ok[gi] = 32'(wr_sel_a[gi]) < NREGS;
`ifdef RF_R0_ZERO_EN
        assign wr_commit[gi]   = wr_en[gi] && wr_range_ok[gi] && (wr_sel_a[gi] != '0);
`else
        assign wr_commit[gi]   = wr_en[gi] && wr_range_ok[gi];
`endif
    end

    // Storage: one flop bank per register so reset clears it without a clock.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [DW-1:0] data_reg;
        logic [DW-1:0] data_next;

        always_comb begin
            data_next = data_reg;
            // Later ports override earlier ones: port 1 wins a collision.
            for (int w = 0; w < NWR; w++) begin
                if (wr_commit[w] && (wr_sel_a[w] == SELW'(gi))) begin
                    data_next = wr_data_a[w];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg <= '0;
            end else begin
                data_reg <= data_next;
            end
        end

        assign mem_q[gi] = data_reg;
    end

    // Read ports.
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        rf_bypass_port #(
            .DW    (DW),
            .NREGS (NREGS),
            .NWR   (NWR),
            .SELW  (SELW)
        ) u_port (
            .rst_n     (rst_n),
            .rd_sel    (rd_sel[gi*SELW +: SELW]),
            .mem       (mem_q),
            .wr_commit (wr_commit),
            .wr_sel    (wr_sel),
            .wr_data   (wr_data),
            .rd_data   (rd_data[gi*DW +: DW]),
            .range_err (rd_range_err[gi])
        );
    end

    // Collision uses raw enables so it is flagged even on register 0.
    if (NWR == 2) begin : g_collide
        assign wr_collide = wr_en[0] && wr_en[1] && (wr_sel_a[0] == wr_sel_a[1]);
    end else begin : g_no_collide
        assign wr_collide = 1'b0;
    end

    assign wr_range_err = |(wr_en & ~wr_range_ok);

    always_comb begin
        x_err     = $isunknown({wr_en, wr_sel, wr_data});
        err_cause = ERR_NONE;
        if (rd_range_err != '0) err_cause = ERR_RANGE_RD;
        if (wr_range_err)       err_cause = ERR_RANGE_WR;
        if (wr_collide)         err_cause = ERR_COLLIDE;
        if (x_err)              err_cause = ERR_X;
    end

    assign err = rst_n && (err_cause != ERR_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_reg <= 1'b0;
        end else if (err) begin
            err_sticky_reg <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_rf_bypass_mp.sv
// Bench for rf_bypass_mp: a default 8-register instance driven from a vector
// table plus hand sequences, and a 6-register instance for range handling.
module tb_rf_bypass_mp;

    logic        clk;
    logic        rst_n;

    // Default instance: DW=16, NREGS=8, NRD=2, NWR=2, SELW=3.
    logic [5:0]  rd_sel;
    logic [31:0] rd_data;
    logic [1:0]  wr_en;
    logic [5:0]  wr_sel;
    logic [31:0] wr_data;
    logic        err;
    logic        err_sticky;

    // Six-register instance, SELW=3.
    logic [5:0]  b_rd_sel;
    logic [31:0] b_rd_data;
    logic [1:0]  b_wr_en;
    logic [5:0]  b_wr_sel;
    logic [31:0] b_wr_data;
    logic        b_err;
    logic        b_err_sticky;

    int checks   = 0;
    int failures = 0;

`ifdef RF_R0_ZERO_EN
    localparam logic [15:0] R0W = 16'h0000;
    localparam logic [15:0] R0C = 16'h0000;
`else
    localparam logic [15:0] R0W = 16'hFFFF;
    localparam logic [15:0] R0C = 16'h5555;
`endif

    rf_bypass_mp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .err        (err),
        .err_sticky (err_sticky)
    );

    rf_bypass_mp #(.DW(16), .NREGS(6), .NRD(2), .NWR(2)) dut6 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_sel     (b_rd_sel),
        .rd_data    (b_rd_data),
        .wr_en      (b_wr_en),
        .wr_sel     (b_wr_sel),
        .wr_data    (b_wr_data),
        .err        (b_err),
        .err_sticky (b_err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  en;
        logic [2:0]  ws0;
        logic [15:0] wd0;
        logic [2:0]  ws1;
        logic [15:0] wd1;
        logic [2:0]  rs0;
        logic [2:0]  rs1;
        logic [15:0] e0;
        logic [15:0] e1;
        logic        eerr;
        logic        estk;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [2:0] ws0, input logic [15:0] wd0,
                         input logic [2:0] ws1, input logic [15:0] wd1,
                         input logic [2:0] rs0, input logic [2:0] rs1);
        wr_en   = en;
        wr_sel  = {ws1, ws0};
        wr_data = {wd1, wd0};
        rd_sel  = {rs1, rs0};
    endtask

    task automatic drive6(input logic [1:0] en, input logic [2:0] ws0, input logic [15:0] wd0,
                          input logic [2:0] ws1, input logic [15:0] wd1,
                          input logic [2:0] rs0, input logic [2:0] rs1);
        b_wr_en   = en;
        b_wr_sel  = {ws1, ws0};
        b_wr_data = {wd1, wd0};
        b_rd_sel  = {rs1, rs0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          en     ws0   wd0       ws1   wd1       rs0   rs1   e0        e1        err   stk
        vt[0]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd0, 3'd1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vt[1]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd2, 3'd3, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vt[2]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd4, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vt[3]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd6, 3'd7, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vt[4]  = '{2'b01, 3'd3, 16'hA5A5, 3'd0, 16'h0000, 3'd3, 3'd0, 16'hA5A5, 16'h0000, 1'b0, 1'b0};
        vt[5]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0};
        vt[6]  = '{2'b11, 3'd5, 16'h1111, 3'd5, 16'h2222, 3'd5, 3'd3, 16'h2222, 16'hA5A5, 1'b1, 1'b0};
        vt[7]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd5, 3'd5, 16'h2222, 16'h2222, 1'b0, 1'b1};
        vt[8]  = '{2'b11, 3'd1, 16'h0001, 3'd2, 16'h0BEE, 3'd1, 3'd2, 16'h0001, 16'h0BEE, 1'b0, 1'b1};
        vt[9]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd1, 3'd2, 16'h0001, 16'h0BEE, 1'b0, 1'b1};
        vt[10] = '{2'b10, 3'd2, 16'hDEAD, 3'd1, 16'h7777, 3'd1, 3'd2, 16'h7777, 16'h0BEE, 1'b0, 1'b1};
        vt[11] = '{2'b01, 3'd0, 16'hFFFF, 3'd0, 16'h0000, 3'd0, 3'd0, R0W,      R0W,      1'b0, 1'b1};
        vt[12] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd0, 3'd1, R0W,      16'h7777, 1'b0, 1'b1};
        vt[13] = '{2'b11, 3'd0, 16'hAAAA, 3'd0, 16'h5555, 3'd0, 3'd4, R0C,      16'h0000, 1'b1, 1'b1};
        vt[14] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd0, 3'd6, R0C,      16'h0000, 1'b0, 1'b1};

        // Reset with a write in flight: bypass must be gated off.
        rst_n = 1'b0;
        drive(2'b01, 3'd3, 16'hFFFF, 3'd0, 16'h0000, 3'd3, 3'd3);
        drive6(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd0, 3'd0);
        #2;
        check("rst_rd0", {16'h0, rd_data[15:0]}, 32'h0);
        check("rst_rd1", {16'h0, rd_data[31:16]}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_sticky", {31'h0, err_sticky}, 32'h0);
        $display("reset rd0=%h rd1=%h err=%b sticky=%b", rd_data[15:0], rd_data[31:16], err, err_sticky);
        drive(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].en, vt[i].ws0, vt[i].wd0, vt[i].ws1, vt[i].wd1, vt[i].rs0, vt[i].rs1);
            #3;
            check($sformatf("v%0d_rd0", i), {16'h0, rd_data[15:0]}, {16'h0, vt[i].e0});
            check($sformatf("v%0d_rd1", i), {16'h0, rd_data[31:16]}, {16'h0, vt[i].e1});
            check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vt[i].eerr});
            check($sformatf("v%0d_sticky", i), {31'h0, err_sticky}, {31'h0, vt[i].estk});
            $display("vec %0d en=%b rd0=%h rd1=%h err=%b sticky=%b", i, vt[i].en,
                     rd_data[15:0], rd_data[31:16], err, err_sticky);
            step();
        end

        // Reset pulse between edges: storage clears at once, in-flight write lost.
        drive(2'b01, 3'd2, 16'h1234, 3'd0, 16'h0000, 3'd2, 3'd2);
        #1;
        check("rp_bypass", {16'h0, rd_data[15:0]}, 32'h1234);
        step();
        drive(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd2, 3'd2);
        #1;
        check("rp_stored", {16'h0, rd_data[15:0]}, 32'h1234);
        drive(2'b01, 3'd2, 16'hBEEF, 3'd0, 16'h0000, 3'd2, 3'd2);
        rst_n = 1'b0;
        #1;
        check("rp_rd_low", {16'h0, rd_data[15:0]}, 32'h0);
        check("rp_err_low", {31'h0, err}, 32'h0);
        check("rp_sticky_low", {31'h0, err_sticky}, 32'h0);
        drive(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd2, 3'd2);
        #1;
        rst_n = 1'b1;
        #1;
        check("rp_rd_rel", {16'h0, rd_data[15:0]}, 32'h0);
        step();
        #1;
        check("rp_rd_next", {16'h0, rd_data[31:16]}, 32'h0);
        check("rp_sticky_next", {31'h0, err_sticky}, 32'h0);
        $display("rstpulse rd0=%h sticky=%b", rd_data[15:0], err_sticky);

        // Six-register instance: out-of-range reads and writes.
        drive6(2'b01, 3'd4, 16'h4444, 3'd0, 16'h0000, 3'd4, 3'd7);
        #1;
        check("r6_byp4", {16'h0, b_rd_data[15:0]}, 32'h4444);
        check("r6_rd7", {16'h0, b_rd_data[31:16]}, 32'h0);
        check("r6_rd7_err", {31'h0, b_err}, 32'h1);
        $display("r6 rd7 rd0=%h rd1=%h err=%b", b_rd_data[15:0], b_rd_data[31:16], b_err);
        step();
        drive6(2'b01, 3'd6, 16'hDEAD, 3'd0, 16'h0000, 3'd6, 3'd4);
        #1;
        check("r6_rd6", {16'h0, b_rd_data[15:0]}, 32'h0);
        check("r6_rd4", {16'h0, b_rd_data[31:16]}, 32'h4444);
        check("r6_wr6_err", {31'h0, b_err}, 32'h1);
        $display("r6 wr6 rd0=%h rd1=%h err=%b", b_rd_data[15:0], b_rd_data[31:16], b_err);
        step();
        for (int r = 0; r < 6; r++) begin
            drive6(2'b00, 3'd6, 16'hDEAD, 3'd7, 16'hDEAD, 3'(r), 3'(5 - r));
            #1;
            check($sformatf("r6_reg%0d", r), {16'h0, b_rd_data[15:0]}, (r == 4) ? 32'h4444 : 32'h0);
            check($sformatf("r6_reg%0d_b", 5 - r), {16'h0, b_rd_data[31:16]}, (r == 1) ? 32'h4444 : 32'h0);
            check($sformatf("r6_reg%0d_err", r), {31'h0, b_err}, 32'h0);
            $display("r6 scan %0d rd0=%h rd1=%h err=%b", r, b_rd_data[15:0], b_rd_data[31:16], b_err);
            step();
        end
        check("r6_sticky", {31'h0, b_err_sticky}, 32'h1);
        drive6(2'b10, 3'd0, 16'h0000, 3'd7, 16'h9999, 3'd1, 3'd2);
        #1;
        check("r6_wr7_err", {31'h0, b_err}, 32'h1);
        $display("r6 wr7 err=%b", b_err);
        step();
        drive6(2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 3'd0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
